// File: rtl/button_conditioner.sv
// button_conditioner
//   Input conditioning for the lab 4 adder top level. It brings the raw
//   active-low LoadB/Run push-buttons and the 16 slider switches into the
//   Clk domain through two flip-flops each. It debounces both buttons and
//   produces a one-cycle press pulse for each accepted press.
//
// Ports
//   Clk          50 MHz system clock
//   Reset        synchronous, active-low reset (KEY0, unconditioned)
//   LoadB_raw    raw push-button 1, active low, asynchronous
//   Run_raw      raw push-button 3, active low, asynchronous
//   SW_raw[15:0] raw slider switches, asynchronous
//   LoadB        debounced LoadB level, active low
//   Run          debounced Run level, active low
//   LoadB_press  one-cycle active-high pulse per accepted LoadB press
//   Run_press    one-cycle active-high pulse per accepted Run press
//   SW[15:0]     two-stage synchronized switches (not debounced)

// Per-button debouncer. It accepts a new synchronized level only after the
// level has differed from the accepted level for DEBOUNCE_CYCLES consecutive
// edges. Any return to the accepted level clears the count, so a bounce
// restarts the hold from zero.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic Clk,
  input  logic Reset,
  input  logic sync_in,
  output logic level,
  output logic press
);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      level <= 1'b1;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      press <= 1'b0;
      if (sync_in == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_in;
        cnt   <= '0;
        // Pulse only on an accepted press (1->0), never on release.
        press <= ~sync_in;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        LoadB_raw,
  input  logic        Run_raw,
  input  logic [15:0] SW_raw,
  output logic        LoadB,
  output logic        Run,
  output logic        LoadB_press,
  output logic        Run_press,
  output logic [15:0] SW
);
  localparam int CNT_W     = $clog2(DEBOUNCE_CYCLES);
  localparam int NUM_LANES = 2;  // lane 0 = LoadB, lane 1 = Run

  logic [NUM_LANES-1:0] btn_raw, btn_s1, btn_s2, btn_level, btn_press;
  logic [15:0]          sw_s1, sw_s2;

  assign btn_raw = {Run_raw, LoadB_raw};

  // Two-flop synchronizers. Buttons reset to released (1), switches to 0.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      btn_s1 <= '1;
      btn_s2 <= '1;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      sw_s1  <= SW_raw;
      sw_s2  <= sw_s1;
    end
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    button_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_db (
      .Clk    (Clk),
      .Reset  (Reset),
      .sync_in(btn_s2[g]),
      .level  (btn_level[g]),
      .press  (btn_press[g])
    );
  end

  assign LoadB       = btn_level[0];
  assign Run         = btn_level[1];
  assign LoadB_press = btn_press[0];
  assign Run_press   = btn_press[1];
  assign SW          = sw_s2;
endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;
  localparam int D = 4;

  logic        Clk = 1'b0;
  logic        Reset, LoadB_raw, Run_raw;
  logic [15:0] SW_raw;
  logic        LoadB, Run, LoadB_press, Run_press;
  logic [15:0] SW;

  int n_cmp = 0;
  int n_bad = 0;

  button_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .Clk(Clk), .Reset(Reset), .LoadB_raw(LoadB_raw), .Run_raw(Run_raw),
    .SW_raw(SW_raw), .LoadB(LoadB), .Run(Run), .LoadB_press(LoadB_press),
    .Run_press(Run_press), .SW(SW)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. The synchronizer is a plain 2-sample delay. A button's
  // accepted level flips to v when the last D delayed samples are all v and
  // v differs from the current level.
  bit        m_s1 [2];
  bit        m_s2 [2];
  bit        m_stable [2];
  bit        m_press [2];
  bit [15:0] m_sw1, m_sw2;
  bit        hist0[$];
  bit        hist1[$];

  function automatic bit window_is(input bit q[$], input bit v);
    if (q.size() < D) return 1'b0;
    foreach (q[i]) if (q[i] != v) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input bit rst_n, input bit lb, input bit rn, input bit [15:0] sw);
    bit raw [2];
    raw[0] = lb; raw[1] = rn;
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        m_s1[b] = 1; m_s2[b] = 1; m_stable[b] = 1; m_press[b] = 0;
      end
      m_sw1 = '0; m_sw2 = '0;
      hist0.delete(); hist1.delete();
    end else begin
      hist0.push_back(m_s2[0]); if (hist0.size() > D) void'(hist0.pop_front());
      hist1.push_back(m_s2[1]); if (hist1.size() > D) void'(hist1.pop_front());
      for (int b = 0; b < 2; b++) begin
        m_press[b] = 0;
        if (window_is((b == 0) ? hist0 : hist1, ~m_stable[b])) begin
          m_stable[b] = ~m_stable[b];
          m_press[b]  = (m_stable[b] == 0);
        end
      end
      for (int b = 0; b < 2; b++) begin
        m_s2[b] = m_s1[b];
        m_s1[b] = raw[b];
      end
      m_sw2 = m_sw1; m_sw1 = sw;
    end
  endtask

  // One clock edge: model advances on the inputs present at the edge, DUT
  // outputs are sampled 1 time unit later and compared with the model.
  task automatic step();
    bit r, l, n; bit [15:0] s;
    r = Reset; l = LoadB_raw; n = Run_raw; s = SW_raw;
    @(posedge Clk);
    model_edge(r, l, n, s);
    #1;
    chk("model_LoadB",  16'(LoadB),       16'(m_stable[0]));
    chk("model_Run",    16'(Run),         16'(m_stable[1]));
    chk("model_LBpress",16'(LoadB_press), 16'(m_press[0]));
    chk("model_RNpress",16'(Run_press),   16'(m_press[1]));
    chk("model_SW",     SW,               16'(m_sw2));
  endtask

  typedef struct {
    logic rst_n, lb, rn; logic [15:0] sw;
    logic e_lb, e_rn, e_lbp, e_rnp; logic [15:0] e_sw;
  } vec_t;
  vec_t vt[$];

  task automatic add(input logic rst_n, lb, rn, input logic [15:0] sw,
                     input logic e_lb, e_rn, e_lbp, e_rnp, input logic [15:0] e_sw);
    vec_t v;
    v.rst_n = rst_n; v.lb = lb; v.rn = rn; v.sw = sw;
    v.e_lb = e_lb; v.e_rn = e_rn; v.e_lbp = e_lbp; v.e_rnp = e_rnp; v.e_sw = e_sw;
    vt.push_back(v);
  endtask

  int fall_e, rise_e, pcnt, pedge, pcnt2;

  initial begin
    Reset = 1'b0; LoadB_raw = 1'b1; Run_raw = 1'b1; SW_raw = '0;

    // Reset with buttons held and switches all ones.
    add(0, 0, 0, 16'hFFFF, 1, 1, 0, 0, 16'h0000);
    add(0, 0, 0, 16'hFFFF, 1, 1, 0, 0, 16'h0000);
    // Switch synchronizer latency: 2 edges.
    add(1, 1, 1, 16'hA5C3, 1, 1, 0, 0, 16'h0000);
    add(1, 1, 1, 16'hA5C3, 1, 1, 0, 0, 16'hA5C3);
    add(1, 1, 1, 16'h1234, 1, 1, 0, 0, 16'hA5C3);
    add(1, 1, 1, 16'h1234, 1, 1, 0, 0, 16'h1234);
    // Both buttons fall together: accepted at edge D+2, pulses coincide.
    for (int e = 1; e <= 5; e++) add(1, 0, 0, 16'h1234, 1, 1, 0, 0, 16'h1234);
    add(1, 0, 0, 16'h1234, 0, 0, 1, 1, 16'h1234);
    add(1, 0, 0, 16'h1234, 0, 0, 0, 0, 16'h1234);
    add(1, 0, 0, 16'h1234, 0, 0, 0, 0, 16'h1234);
    // Release both: back to 1 at edge 6, no pulse.
    for (int e = 1; e <= 5; e++) add(1, 1, 1, 16'h1234, 0, 0, 0, 0, 16'h1234);
    add(1, 1, 1, 16'h1234, 1, 1, 0, 0, 16'h1234);
    add(1, 1, 1, 16'h1234, 1, 1, 0, 0, 16'h1234);

    foreach (vt[i]) begin
      Reset = vt[i].rst_n; LoadB_raw = vt[i].lb; Run_raw = vt[i].rn; SW_raw = vt[i].sw;
      step();
      chk($sformatf("vec%0d_LoadB", i),  16'(LoadB),       16'(vt[i].e_lb));
      chk($sformatf("vec%0d_Run", i),    16'(Run),         16'(vt[i].e_rn));
      chk($sformatf("vec%0d_LBpress", i),16'(LoadB_press), 16'(vt[i].e_lbp));
      chk($sformatf("vec%0d_RNpress", i),16'(Run_press),   16'(vt[i].e_rnp));
      chk($sformatf("vec%0d_SW", i),     SW,               vt[i].e_sw);
    end

    // LoadB held 20 cycles: fall at edge 6, single pulse at edge 6.
    LoadB_raw = 1'b0; fall_e = 0; pcnt = 0; pedge = 0;
    for (int e = 1; e <= 20; e++) begin
      step();
      if (!LoadB && fall_e == 0) fall_e = e;
      if (LoadB_press) begin pcnt++; pedge = e; end
    end
    chk("lb_fall_edge", 16'(fall_e), 16'(6));
    chk("lb_press_count", 16'(pcnt), 16'(1));
    chk("lb_press_edge", 16'(pedge), 16'(6));
    LoadB_raw = 1'b1; rise_e = 0; pcnt = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (LoadB && rise_e == 0) rise_e = e;
      if (LoadB_press) pcnt++;
    end
    chk("lb_rise_edge", 16'(rise_e), 16'(6));
    chk("lb_release_pulse", 16'(pcnt), 16'(0));

    // Run bounce: 3 low / 1 high, three times -> never accepted.
    fall_e = 0; pcnt = 0;
    for (int rep = 0; rep < 3; rep++) begin
      for (int k = 0; k < 4; k++) begin
        Run_raw = (k == 3);
        step();
        if (!Run) fall_e++;
        if (Run_press) pcnt++;
      end
    end
    for (int e = 0; e < 8; e++) begin
      step();
      if (!Run) fall_e++;
      if (Run_press) pcnt++;
    end
    chk("bounce_run_low", 16'(fall_e), 16'(0));
    chk("bounce_run_press", 16'(pcnt), 16'(0));

    // Run held, reset pulse at edge 4 discards the count.
    Run_raw = 1'b0;
    for (int e = 1; e <= 3; e++) step();
    Reset = 1'b0; step(); Reset = 1'b1;
    chk("rst_mid_run", 16'(Run), 16'(1));
    fall_e = 0; pcnt = 0;
    for (int e = 1; e <= 12; e++) begin
      step();
      if (!Run && fall_e == 0) fall_e = e;
      if (Run_press) pcnt++;
    end
    chk("rst_run_fall_edge", 16'(fall_e), 16'(6));
    chk("rst_run_press_count", 16'(pcnt), 16'(1));
    Run_raw = 1'b1;
    for (int e = 0; e < 8; e++) step();

    // Random stimulus against the model: sticky buttons, rare resets.
    pcnt = 0; pcnt2 = 0;
    for (int c = 0; c < 3000; c++) begin
      Reset = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 5) == 0) LoadB_raw = ~LoadB_raw;
      if ($urandom_range(0, 4) == 0) Run_raw = ~Run_raw;
      SW_raw = 16'($urandom);
      step();
      if (LoadB_press) pcnt++;
      if (Run_press) pcnt2++;
    end
    chk("rand_lb_pressed", 16'(pcnt > 0), 16'(1));
    chk("rand_rn_pressed", 16'(pcnt2 > 0), 16'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
